// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared SD CMD-path types, frame widths and the CRC7 step function.
package sd_cmd_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_e;

   localparam logic [6:0] CRC7_POLY = 7'h09;
   localparam int         R1_WIDTH  = 48;
   localparam int         R2_WIDTH  = 136;

   // one serial step of x^7+x^3+1, MSB-first
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      return {crc[5:0], 1'b0} ^ ((crc[6] ^ din) ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/s_pn_rsp_if.sv
// s_pn_rsp_if: CMD-line receive bus; master is the CMD controller, slave is the receiver.
interface s_pn_rsp_if #(
   parameter int RSP_WIDTH = 48
);
   logic                 enable;
   logic                 serial_in;
   logic [RSP_WIDTH-1:0] response;
   logic                 push;
   logic                 ready;
   logic                 timeout;
   logic                 frame_err;
   logic                 crc_err;

   modport master (
      output enable, serial_in,
      input  response, push, ready, timeout, frame_err, crc_err
   );

   modport slave (
      input  enable, serial_in,
      output response, push, ready, timeout, frame_err, crc_err
   );
endinterface

// File: rtl/crc7_serial.sv
// crc7_serial: bit-serial CRC7 accumulator (initial value 0), shared by the CMD rx and tx paths.
module crc7_serial
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       shift_en,
   input  logic       din,
   output logic [6:0] crc
);
   logic [6:0] crc_q, crc_d;

   always_comb crc_d = clear ? 7'h00 : shift_en ? crc7_step(crc_q, din) : crc_q;

   always_ff @(posedge clk) begin
      crc_q <= reset ? 7'h00 : crc_d;
   end

   assign crc = crc_q;
endmodule

// File: rtl/s_pn_rsp.sv
// s_pn_rsp: SD CMD-line response receiver: start-bit hunt, MSB-first capture, end-bit check.
// Defining S_PN_RSP_CRC7_EN adds a CRC7 check of frame bits [RSP_WIDTH-1:8] against bits [7:1].
module s_pn_rsp
   import sd_cmd_pkg::*;
#(
   parameter int RSP_WIDTH = R1_WIDTH,
   parameter int TIMEOUT   = 64
) (
   input  logic      clk,
   input  logic      reset,
   s_pn_rsp_if.slave bus
);
   localparam int BW = $clog2(RSP_WIDTH + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   state_e               state_q, state_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
   logic [RSP_WIDTH-1:0] shift_q, shift_d, response_q, response_d;
   logic                 push_q, push_d, frame_err_q, frame_err_d, crc_err_q, crc_err_d;
   logic [RSP_WIDTH-1:0] shifted;
   logic                 start, last, wait_over, crc_bad;

   // the first bit lands in the LSB and has climbed to RSP_WIDTH-1 by the end bit
   assign shifted   = {shift_q[RSP_WIDTH-2:0], bus.serial_in};
   assign start     = state_q == WAIT_START && bus.enable && !bus.serial_in;
   assign last      = state_q == RECEIVE && bus.enable && bit_cnt_q == BW'(1);
   assign wait_over = state_q == WAIT_START && bus.enable && bus.serial_in
                      && wait_cnt_q == WW'(TIMEOUT - 1);

`ifdef S_PN_RSP_CRC7_EN
   logic [6:0] crc;

   crc7_serial u_crc (
      .clk      (clk),
      .reset    (reset),
      .clear    (state_q == IDLE),
      .shift_en (start || (state_q == RECEIVE && bit_cnt_q > BW'(8))),
      .din      (bus.serial_in),
      .crc      (crc)
   );

   // while the end bit is sampled, shift_q[6:0] holds frame bits [7:1]
   assign crc_bad = crc != shift_q[6:0];
`else
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      case (state_q)
         IDLE:       state_d = bus.enable ? WAIT_START : IDLE;
         WAIT_START: state_d = (!bus.enable || wait_over) ? IDLE : start ? RECEIVE : WAIT_START;
         RECEIVE:    state_d = !bus.enable ? IDLE : last ? DONE : RECEIVE;
         default:    state_d = IDLE;
      endcase
      wait_cnt_d  = (state_q == WAIT_START && state_d == WAIT_START) ? wait_cnt_q + 1'b1 : '0;
      bit_cnt_d   = start ? BW'(RSP_WIDTH - 1)
                  : (state_q == RECEIVE && state_d == RECEIVE) ? bit_cnt_q - 1'b1 : '0;
      shift_d     = (start || state_q == RECEIVE) ? shifted : shift_q;
      push_d      = last;
      response_d  = last ? shifted : response_q;
      frame_err_d = last ? !bus.serial_in : frame_err_q;
      crc_err_d   = last ? crc_bad : crc_err_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         shift_q     <= '0;
         response_q  <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         crc_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         shift_q     <= shift_d;
         response_q  <= response_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
         crc_err_q   <= crc_err_d;
      end
   end

   assign bus.response  = response_q;
   assign bus.push      = push_q;
   assign bus.ready     = state_q == IDLE;
   assign bus.timeout   = wait_over;
   assign bus.frame_err = frame_err_q;
   assign bus.crc_err   = crc_err_q;
endmodule

// File: tb/tb_s_pn_rsp.sv
// tb_s_pn_rsp: directed bench for s_pn_rsp with a push-time scoreboard.
// Expected crc_err for corrupted-CRC frames follows S_PN_RSP_CRC7_EN.
module tb_s_pn_rsp;
   import sd_cmd_pkg::*;

   localparam int W  = R1_WIDTH;
   localparam int TO = 64;
`ifdef S_PN_RSP_CRC7_EN
   localparam logic CRC_ON = 1'b1;
`else
   localparam logic CRC_ON = 1'b0;
`endif

   localparam logic [W-1:0] F_CMD0   = 48'h40_0000_0000_95;
   localparam logic [W-1:0] F_BADCRC = 48'h40_0000_0000_97;
   localparam logic [W-1:0] F_BADEND = 48'h40_0000_0000_94;
   localparam logic [W-1:0] F_CMD8   = 48'h48_0000_01AA_87;
   localparam logic [W-1:0] F_CMD8X  = 48'h48_0000_01AB_87;
   localparam logic [W-1:0] F_STRAY  = 48'h0F0F_0F0F_0F0F;

   typedef struct {
      logic [W-1:0] rsp;
      logic         fe;
      logic         ce;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_push = 0;
   int   n_exp_push = 0;
   int   n_timeout = 0;
   exp_t sb[$];
   exp_t e_mon;

   s_pn_rsp_if #(.RSP_WIDTH(W)) bus ();

   s_pn_rsp #(.RSP_WIDTH(W), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         bus.serial_in = 1'b1;
      end
   endtask

   task automatic send_bits(input logic [W-1:0] f, input int n);
      for (int i = W - 1; i >= W - n; i--) begin
         tick();
         bus.serial_in = f[i];
      end
   endtask

   task automatic send_frame(input logic [W-1:0] f, input logic fe, input logic ce);
      sb.push_back('{f, fe, ce});
      n_exp_push++;
      send_bits(f, W);
      tick();
      bus.serial_in = 1'b1;
      @(negedge clk);
      check("push_latency", 64'(bus.push), 64'(1));
      tick();
      @(negedge clk);
      check("push_one_cycle", 64'(bus.push), 64'(0));
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
   endtask

   // scoreboard: every push must match the oldest outstanding frame
   always @(negedge clk) begin
      if (bus.timeout === 1'b1) n_timeout++;
      if (bus.push === 1'b1) begin
         n_push++;
         check("push_timeout_excl", 64'(bus.timeout), 64'(0));
         n_checks++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_push: observed response %0h expected no push", bus.response);
         end
         if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            check("response", 64'(bus.response), 64'(e_mon.rsp));
            check("frame_err", 64'(bus.frame_err), 64'(e_mon.fe));
            check("crc_err", 64'(bus.crc_err), 64'(e_mon.ce));
         end
      end
   end

   initial begin
      int k;
      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.serial_in = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_response", 64'(bus.response), 64'(0));
      check("rst_push", 64'(bus.push), 64'(0));
      check("rst_timeout", 64'(bus.timeout), 64'(0));
      check("rst_frame_err", 64'(bus.frame_err), 64'(0));
      check("rst_crc_err", 64'(bus.crc_err), 64'(0));
      check("rst_ready", 64'(bus.ready), 64'(1));

      // back-to-back frames with enable held high
      tick();
      bus.enable = 1'b1;
      idle(5);
      send_frame(F_CMD0, 1'b0, 1'b0);
      idle(3);
      send_frame(F_BADCRC, 1'b0, CRC_ON);
      idle(2);
      send_frame(F_CMD8, 1'b0, 1'b0);
      idle(2);
      send_frame(F_CMD8X, 1'b0, CRC_ON);
      idle(2);
      send_frame(F_BADEND, 1'b1, 1'b0);

      // timeout after TO waiting cycles
      tick();
      bus.enable = 1'b0;
      idle(2);
      @(negedge clk);
      check("ready_idle", 64'(bus.ready), 64'(1));
      tick();
      bus.enable = 1'b1;
      @(posedge clk);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.timeout !== 1'b1 && k < 200);
      check("timeout_cycle", 64'(k), 64'(TO));
      check("ready_while_waiting", 64'(bus.ready), 64'(0));
      @(negedge clk);
      check("timeout_pulse", 64'(bus.timeout), 64'(0));
      check("ready_after_timeout", 64'(bus.ready), 64'(1));
      tick();
      bus.enable = 1'b0;
      idle(3);
      check("timeout_once", 64'(n_timeout), 64'(1));
      check("no_push_on_timeout", 64'(n_push), 64'(n_exp_push));
      check("response_held", 64'(bus.response), 64'(F_BADEND));
      check("frame_err_held", 64'(bus.frame_err), 64'(1));

      // start bit on the last waiting cycle beats the timeout
      tick();
      bus.enable = 1'b1;
      repeat (63) tick();
      send_frame(F_CMD0, 1'b0, 1'b0);
      check("start_beats_timeout", 64'(n_timeout), 64'(1));

      // abort mid-frame, then a clean frame
      tick();
      bus.enable = 1'b0;
      idle(2);
      tick();
      bus.enable = 1'b1;
      idle(2);
      send_bits(F_CMD0, 20);
      tick();
      bus.enable    = 1'b0;
      bus.serial_in = 1'b1;
      tick();
      @(negedge clk);
      check("ready_after_abort", 64'(bus.ready), 64'(1));
      idle(3);
      check("no_push_on_abort", 64'(n_push), 64'(n_exp_push));
      tick();
      bus.enable = 1'b1;
      idle(2);
      send_frame(F_CMD8, 1'b0, 1'b0);

      // reset at bit 30 of a frame
      idle(2);
      send_frame(F_BADEND, 1'b1, 1'b0);
      idle(2);
      send_bits(F_CMD0, 30);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_response", 64'(bus.response), 64'(0));
      check("midrst_frame_err", 64'(bus.frame_err), 64'(0));
      check("midrst_crc_err", 64'(bus.crc_err), 64'(0));
      check("midrst_push", 64'(bus.push), 64'(0));
      check("midrst_timeout", 64'(bus.timeout), 64'(0));
      check("midrst_ready", 64'(bus.ready), 64'(1));
      reset      = 1'b0;
      bus.enable = 1'b0;
      send_bits(F_STRAY, 12);
      @(negedge clk);
      check("stray_ready", 64'(bus.ready), 64'(1));
      check("stray_no_push", 64'(n_push), 64'(n_exp_push));
      tick();
      bus.enable = 1'b1;
      idle(3);
      send_frame(F_CMD0, 1'b0, 1'b0);

      tick();
      bus.enable = 1'b0;
      idle(4);
      check("final_push_count", 64'(n_push), 64'(n_exp_push));
      check("final_timeouts", 64'(n_timeout), 64'(1));
      check("final_scoreboard", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
